spi_reg_writer: RTL
===================

# spi_reg_writer

SPI controller that drives the chip's SPI register-map peripheral from on-chip logic, such as a test sequencer or configuration loader. Each accepted request is serialised into one 16-bit mode-0 frame: SCLK idles low, COPI changes while SCLK is low, and COPI is sampled on the SCLK rising edge, MSB first. Frame format is {rw, addr[6:0], data[7:0]}; the peripheral commits only frames with rw=1. All SPI outputs are registered and are generated from clk, so the peripheral's 2-flop synchronisers see clean, slow edges.

## Interface
Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; legal range 2..255.
- CS_SETUP, 2: clk cycles from nCS falling to the start of the first SCLK low phase; legal range 1..255.
- CS_HOLD, 2: clk cycles from the last SCLK falling edge to nCS rising; legal range 2..255.
- CS_IDLE, 4: minimum clk cycles nCS stays high between frames and after reset; legal range 3..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  rw bit of the frame (1 = write).
- req_addr  in  7  register address.
- req_data  in  8  register data.
- done  out  1  one-cycle pulse when a frame completes.
- sclk  out  1  SPI clock.
- ncs  out  1  chip select, active-low.
- copi  out  1  serial data to the peripheral.

## Operation
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP. A single 8-bit phase counter, a 5-bit edge counter and a 16-bit shift register.
- Reset (asynchronous, takes effect immediately even mid-frame):
  - State goes to GAP with the counter loaded to CS_IDLE.
  - ncs=1, sclk=0, copi=0, req_ready=0, done=0.
  - No done pulse is generated for an aborted frame.
- IDLE:
  - Outputs: req_ready=1, ncs=1, sclk=0, copi=0.
  - Accept a request when req_valid && req_ready.
  - On accept: latch {req_write, req_addr, req_data}, set req_ready=0, ncs=0, copi=frame[15], then go to SETUP.
  - Inputs are don't-care after the accept cycle.
- SETUP: hold for CS_SETUP cycles, then go to SHIFT with sclk low.
- SHIFT:
  - SCLK runs low for CLK_DIV cycles, then high for CLK_DIV cycles; repeat for 16 periods.
  - On each SCLK falling edge after bits 15..1 have been sampled, copi advances to the next lower bit.
  - After the 16th high phase, sclk returns low and the state goes to HOLD. copi keeps bit 0.
- HOLD: hold for CS_HOLD cycles. Then set ncs=1, copi=0, pulse done for 1 cycle, and go to GAP.
- GAP: hold for CS_IDLE cycles, then go to IDLE.
- Parameter values outside the legal ranges are unsupported. Implementations include an elaboration-time check.

## Timing
- Accept on clk edge k. From cycle k+1: ncs=0 and copi=frame[15].
- First sclk rise: cycle k+1+CS_SETUP+CLK_DIV.
- Rising edge n (n = 0..15): cycle k+1+CS_SETUP+CLK_DIV+2·CLK_DIV·n.
- Data stability: copi is stable for at least CLK_DIV cycles before each rise and for CLK_DIV cycles after it.
- ncs low duration: exactly CS_SETUP + 32·CLK_DIV + CS_HOLD cycles. With defaults this is 132 cycles.
- done: high in the first cycle ncs is high again.
- Next request: req_ready returns high CS_IDLE cycles after ncs rises.
- Back-to-back frames with req_valid held high:
  - The next accept happens in the first req_ready cycle.
  - The next ncs falls one cycle later, so the ncs-high gap is CS_IDLE+1 cycles.
- After reset release: req_ready rises CS_IDLE cycles after the first clk edge.
- Exactly 16 sclk rising edges per frame. No sclk edges while ncs=1.

## Test plan
- Reset release, defaults → ncs=1, sclk=0, copi=0, req_ready=0 for 4 cycles, then req_ready=1; no sclk activity.
- Write rw=1, addr=0x04, data=0xA5, with the peripheral attached:
  - copi sampled on the rises = 1,0000100,10100101.
  - ncs low for 132 cycles; done pulses once.
  - Peripheral pwm_duty_cycle becomes 0xA5.
- Back-to-back requests with req_valid held (addr 0x00 data 0xFF, then addr 0x01 data 0x0F):
  - ncs-high gap = 5 cycles.
  - Peripheral en_reg_out_7_0=0xFF and en_reg_out_15_8=0x0F.
  - Two done pulses.
- Read frame rw=0, addr=0x02, data=0x55:
  - First sampled bit = 0.
  - Peripheral en_reg_pwm_7_0 stays 0x00; done still pulses.
- Controller reset only, asserted after the 7th sclk rise of a write to addr 0x03:
  - ncs=1 and sclk=0 within the same cycle; no done.
  - Peripheral en_reg_pwm_15_8 unchanged.
  - A following full frame to addr 0x03 with data 0x3C lands correctly.
- CLK_DIV=2, CS_SETUP=1, CS_HOLD=2, CS_IDLE=3:
  - Write addr 0x04 data 0x81 → peripheral pwm_duty_cycle=0x81.
  - ncs low 67 cycles.

Source files
------------

// File: rtl/spi_reg_writer.sv
// SPI mode-0 master that serialises {rw, addr, data} requests into 16-bit frames
// for the register-map peripheral; every SPI pin is a flop clocked by clk.
module spi_reg_writer #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_IDLE  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       done,
    output logic       sclk,
    output logic       ncs,
    output logic       copi
);

    if (CLK_DIV < 2 || CLK_DIV > 255 || CS_SETUP < 1 || CS_SETUP > 255 ||
        CS_HOLD < 2 || CS_HOLD > 255 || CS_IDLE < 3 || CS_IDLE > 255) begin : g_param_check
        $error("spi_reg_writer: timing parameter outside its legal range");
    end

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    // Phase counter is loaded with (duration - 1) and the state advances when it reads zero.
    localparam logic [7:0] DIV_LOAD   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SETUP_LOAD = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_LOAD  = 8'(CS_HOLD - 1);
    localparam logic [7:0] IDLE_LOAD  = 8'(CS_IDLE - 1);

    state_t      state;
    logic [7:0]  phase_cnt;
    logic [4:0]  edge_cnt;
    logic [15:0] shift_reg;

    // NOTE: all state is updated with non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order inside the block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: reset lands in GAP with a full CS_IDLE count (one more than a normal
            // GAP entry), so req_ready rises exactly CS_IDLE edges after release.
            state     <= GAP;
            phase_cnt <= 8'(CS_IDLE);
            edge_cnt  <= '0;
            shift_reg <= '0;
            req_ready <= 1'b0;
            done      <= 1'b0;
            sclk      <= 1'b0;
            ncs       <= 1'b1;
            copi      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        shift_reg <= {req_write, req_addr, req_data};
                        copi      <= req_write;
                        ncs       <= 1'b0;
                        req_ready <= 1'b0;
                        phase_cnt <= SETUP_LOAD;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase_cnt == '0) begin
                        phase_cnt <= DIV_LOAD;
                        edge_cnt  <= '0;
                        state     <= SHIFT;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                SHIFT: begin
                    if (phase_cnt != '0) begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end else if (edge_cnt == 5'd31) begin
                        // 32nd half-period ends: final fall, copi keeps bit 0.
                        sclk      <= 1'b0;
                        phase_cnt <= HOLD_LOAD;
                        state     <= HOLD;
                    end else begin
                        sclk      <= ~sclk;
                        edge_cnt  <= edge_cnt + 5'd1;
                        phase_cnt <= DIV_LOAD;
                        if (sclk) begin
                            // Falling edge: present the next lower bit (rotate keeps all bits live).
                            copi      <= shift_reg[14];
                            shift_reg <= {shift_reg[14:0], shift_reg[15]};
                        end
                    end
                end
                HOLD: begin
                    if (phase_cnt == '0) begin
                        ncs       <= 1'b1;
                        copi      <= 1'b0;
                        done      <= 1'b1;
                        phase_cnt <= IDLE_LOAD;
                        state     <= GAP;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                GAP: begin
                    if (phase_cnt == '0) begin
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                default: begin
                    state     <= GAP;
                    phase_cnt <= IDLE_LOAD;
                    ncs       <= 1'b1;
                    sclk      <= 1'b0;
                    copi      <= 1'b0;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
